carry_look_ahead_adder: RTL and testbench



---
 rtl/carry_look_ahead_adder_if.sv | 25 ++
 rtl/carry_look_ahead_adder.sv | 104 ++++++++++
 tb/tb_carry_look_ahead_adder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/carry_look_ahead_adder_if.sv
// Operand/result bundle for the registered carry-lookahead adder.
// The master drives operands; the slave (the adder) returns registered results.
interface carry_look_ahead_adder_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             in_valid;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             P_out;
  logic             G_out;
  logic             out_valid;

  modport master (
    output A, B, Cin, in_valid,
    input  S, Cout, P_out, G_out, out_valid
  );

  modport slave (
    input  A, B, Cin, in_valid,
    output S, Cout, P_out, G_out, out_valid
  );
endinterface

// File: rtl/carry_look_ahead_adder.sv
// Two-level carry-lookahead adder with one register stage.
// Level one: 4-bit groups; level two: up to four groups. Carries are sum-of-products.
module carry_look_ahead_adder #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  carry_look_ahead_adder_if.slave  bus
);

  localparam int NG = WIDTH / 4;

  if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 12 || WIDTH == 16)) begin : g_bad_width
    $fatal(1, "carry_look_ahead_adder: WIDTH must be 4, 8, 12 or 16");
  end

  // Carry into position n of a 4-wide g/p slice, as a flat OR of AND terms:
  // g[n-1] | p[n-1]g[n-2] | ... | p[n-1]..p[0]c0. n = 0 returns c0.
  function automatic logic sop_carry(input logic [3:0] g, input logic [3:0] p,
                                     input logic c0, input int n);
    logic term;
    logic acc;
    acc = 1'b0;
    for (int m = 0; m < 4; m++) begin
      if (m < n) begin
        term = g[m];
        for (int q = 0; q < 4; q++) begin
          if (q > m && q < n) term = term & p[q];
        end
        acc = acc | term;
      end
    end
    term = c0;
    for (int q = 0; q < 4; q++) begin
      if (q < n) term = term & p[q];
    end
    return acc | term;
  endfunction

  logic [WIDTH-1:0] g, p, c;
  logic [3:0]       pg, gg;
  logic             grp_cin;

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             pout_d, pout_q;
  logic             gout_d, gout_q;
  logic             vld_q;

  // NOTE: every variable gets a default first, so no path leaves one unassigned
  // and no latch is inferred; unused group slots stay 0 instead of X.
  always_comb begin
    g       = bus.A & bus.B;
    p       = bus.A ^ bus.B;
    pg      = '0;
    gg      = '0;
    c       = '0;
    grp_cin = 1'b0;
    pout_d  = 1'b1;

    for (int k = 0; k < NG; k++) begin
      pg[k] = &p[4*k +: 4];
      gg[k] = sop_carry(g[4*k +: 4], p[4*k +: 4], 1'b0, 4);
    end

    // Each group's carry-in comes straight from the second-level lookahead.
    for (int k = 0; k < NG; k++) begin
      grp_cin = sop_carry(gg, pg, bus.Cin, k);
      for (int j = 0; j < 4; j++) begin
        c[4*k + j] = sop_carry(g[4*k +: 4], p[4*k +: 4], grp_cin, j);
      end
      pout_d = pout_d & pg[k];
    end

    s_d    = p ^ c;
    cout_d = sop_carry(gg, pg, bus.Cin, NG);
    gout_d = sop_carry(gg, pg, 1'b0, NG);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      pout_q <= 1'b0;
      gout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      pout_q <= pout_d;
      gout_q <= gout_d;
      vld_q  <= bus.in_valid;
    end
  end

  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;
  assign bus.P_out     = pout_q;
  assign bus.G_out     = gout_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Directed table plus sequences for WIDTH=4, and random checks at WIDTH 4, 8 and 16
// against an arithmetic reference model.
module tb_carry_look_ahead_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  carry_look_ahead_adder_if #(.WIDTH(4))  bus4();
  carry_look_ahead_adder_if #(.WIDTH(8))  bus8();
  carry_look_ahead_adder_if #(.WIDTH(16)) bus16();

  carry_look_ahead_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  carry_look_ahead_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  carry_look_ahead_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [4:0] sum;
    logic       p;
    logic       g;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic v);
    bus4.A = a; bus4.B = b; bus4.Cin = cin; bus4.in_valid = v;
  endtask

  initial begin
    vecs[0] = '{4'h1, 4'h0, 1'b0, 5'h01, 1'b0, 1'b0};
    vecs[1] = '{4'h2, 4'h4, 1'b1, 5'h07, 1'b0, 1'b0};
    vecs[2] = '{4'hB, 4'h6, 1'b0, 5'h11, 1'b0, 1'b1};
    vecs[3] = '{4'h5, 4'h3, 1'b1, 5'h09, 1'b0, 1'b0};
    vecs[4] = '{4'hF, 4'h0, 1'b1, 5'h10, 1'b1, 1'b0};
    vecs[5] = '{4'hF, 4'hF, 1'b1, 5'h1F, 1'b0, 1'b1};
    vecs[6] = '{4'h0, 4'h0, 1'b0, 5'h00, 1'b0, 1'b0};
    vecs[7] = '{4'hA, 4'h5, 1'b1, 5'h10, 1'b1, 1'b0};
    vecs[8] = '{4'h8, 4'h8, 1'b0, 5'h10, 1'b0, 1'b1};

    // Reset with nonzero operands: outputs zero before any clock edge.
    rst_n = 1'b0;
    drive4(4'hF, 4'hF, 1'b1, 1'b1);
    bus8.A = '0;  bus8.B = '0;  bus8.Cin = 1'b0;  bus8.in_valid = 1'b0;
    bus16.A = '0; bus16.B = '0; bus16.Cin = 1'b0; bus16.in_valid = 1'b0;
    #3;
    check("reset_S",     32'(bus4.S),    32'h0);
    check("reset_Cout",  32'(bus4.Cout), 32'h0);
    check("reset_valid", 32'(bus4.out_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_sum", 32'({bus4.Cout, bus4.S}), 32'h0);
    check("reset_hold_pg",  32'({bus4.P_out, bus4.G_out, bus4.out_valid}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, one result per vector.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive4(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_sum", i),   32'({bus4.Cout, bus4.S}), 32'(vecs[i].sum));
      check($sformatf("vec%0d_P", i),     32'(bus4.P_out),     32'(vecs[i].p));
      check($sformatf("vec%0d_G", i),     32'(bus4.G_out),     32'(vecs[i].g));
      check($sformatf("vec%0d_valid", i), 32'(bus4.out_valid), 32'h1);
    end

    // Back-to-back: new operands every cycle; the previous result must still be
    // showing just after the new operands go in, and the new one one edge later.
    begin
      logic [4:0] prev;
      logic [4:0] exp;
      logic [3:0] a, b;
      logic       ci;
      prev = vecs[8].sum;
      for (int i = 0; i < 8; i++) begin
        a  = 4'(i * 3 + 1);
        b  = 4'(15 - i * 2);
        ci = 1'(i);
        exp = {1'b0, a} + {1'b0, b} + {4'b0, ci};
        @(negedge clk);
        drive4(a, b, ci, 1'b1);
        #1;
        check($sformatf("b2b%0d_hold", i), 32'({bus4.Cout, bus4.S}), 32'(prev));
        @(posedge clk);
        #1;
        check($sformatf("b2b%0d_sum", i), 32'({bus4.Cout, bus4.S}), 32'(exp));
        prev = exp;
      end
    end

    // Reset mid-stream.
    @(negedge clk);
    drive4(4'h7, 4'h7, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("mid_pre_sum", 32'({bus4.Cout, bus4.S}), 32'h0F);
    #1 rst_n = 1'b0;
    #1;
    check("mid_async_sum",   32'({bus4.Cout, bus4.S}), 32'h0);
    check("mid_async_valid", 32'(bus4.out_valid), 32'h0);
    @(posedge clk);
    #1;
    check("mid_hold_sum", 32'({bus4.Cout, bus4.S}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive4(4'h3, 4'h4, 1'b0, 1'b0);
    #1;
    check("mid_release_valid", 32'(bus4.out_valid), 32'h0);
    @(posedge clk);
    #1;
    check("mid_noval_sum",   32'({bus4.Cout, bus4.S}), 32'h07);
    check("mid_noval_valid", 32'(bus4.out_valid), 32'h0);
    @(negedge clk);
    drive4(4'h3, 4'h4, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("mid_cap_sum",   32'({bus4.Cout, bus4.S}), 32'h08);
    check("mid_cap_valid", 32'(bus4.out_valid), 32'h1);

    // Random vectors at every instantiated width.
    for (int i = 0; i < 1000; i++) begin
      logic [3:0]  a4, b4;
      logic [7:0]  a8, b8;
      logic [15:0] a16, b16;
      logic        c4, c8, c16;
      logic [4:0]  r4;
      logic [8:0]  r8;
      logic [16:0] r16;
      a4 = 4'($urandom());   b4 = 4'($urandom());   c4 = 1'($urandom());
      a8 = 8'($urandom());   b8 = 8'($urandom());   c8 = 1'($urandom());
      a16 = 16'($urandom()); b16 = 16'($urandom()); c16 = 1'($urandom());
      @(negedge clk);
      drive4(a4, b4, c4, 1'b1);
      bus8.A = a8;   bus8.B = b8;   bus8.Cin = c8;   bus8.in_valid = 1'b1;
      bus16.A = a16; bus16.B = b16; bus16.Cin = c16; bus16.in_valid = 1'b1;
      @(posedge clk);
      #1;
      r4  = {1'b0, a4} + {1'b0, b4} + {4'b0, c4};
      r8  = {1'b0, a8} + {1'b0, b8} + {8'b0, c8};
      r16 = {1'b0, a16} + {1'b0, b16} + {16'b0, c16};
      check("rnd4_sum",  32'({bus4.Cout, bus4.S}), 32'(r4));
      check("rnd4_P",    32'(bus4.P_out), 32'(&(a4 ^ b4)));
      check("rnd4_G",    32'(bus4.G_out), 32'(5'({1'b0, a4} + {1'b0, b4}) >> 4));
      check("rnd8_sum",  32'({bus8.Cout, bus8.S}), 32'(r8));
      check("rnd8_P",    32'(bus8.P_out), 32'(&(a8 ^ b8)));
      check("rnd8_G",    32'(bus8.G_out), 32'(9'({1'b0, a8} + {1'b0, b8}) >> 8));
      check("rnd16_sum", 32'({bus16.Cout, bus16.S}), 32'(r16));
      check("rnd16_P",   32'(bus16.P_out), 32'(&(a16 ^ b16)));
      check("rnd16_G",   32'(bus16.G_out), 32'(17'({1'b0, a16} + {1'b0, b16}) >> 16));
    end

    // Full-width propagate on the wider instances.
    @(negedge clk);
    bus8.A = 8'hA5;    bus8.B = 8'h5A;    bus8.Cin = 1'b1;
    bus16.A = 16'hF0F0; bus16.B = 16'h0F0F; bus16.Cin = 1'b1;
    @(posedge clk);
    #1;
    check("prop8_sum",   32'({bus8.Cout, bus8.S}), 32'h100);
    check("prop8_PG",    32'({bus8.P_out, bus8.G_out}), 32'h2);
    check("prop16_sum",  32'({bus16.Cout, bus16.S}), 32'h10000);
    check("prop16_PG",   32'({bus16.P_out, bus16.G_out}), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
